fft_frame_ctrl: RTL and testbench

Frame sequencer in front of and behind the 256-point parallel DIF FFT core.
- Accepts a complex sample stream through a valid/ready handshake and gates it into the core in frames of exactly 256 samples.
- Waits for the core's output, with a timeout.
- Re-emits the 256 result bins with a bin index and a last marker.
- Counts completed frames and flags timeouts.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_bitrev.sv | 18 +
 rtl/fft_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the 256-point FFT frame controller.
package fft_pkg;

  localparam int FFT_N          = 256;
  localparam int FFT_LOG2N      = 8;
  localparam int FFT_OUT_GROWTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational bit reversal of an index, mapping DIF output order to frequency bin.
module fft_bitrev
  import fft_pkg::*;
#(
  parameter int Log2N = FFT_LOG2N
) (
  input  logic [Log2N-1:0] idx_i,
  output logic [Log2N-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < Log2N; i++) begin
      idx_o[i] = idx_i[Log2N-1-i];
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around the 256-point DIF FFT core: gated input frames, timed wait, indexed drain.
// Define FFT_BITREV_IDX_EN to report out_idx as the bit-reversed (true frequency) bin.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DataWidth = 12,
  parameter int NPoints   = FFT_N,
  parameter int Log2N     = FFT_LOG2N,
  parameter int Timeout   = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                abort,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DataWidth-1:0]                in_re,
  input  logic [DataWidth-1:0]                in_im,
  output logic                                core_start,
  output logic                                core_load,
  output logic [DataWidth-1:0]                core_re,
  output logic [DataWidth-1:0]                core_im,
  input  logic                                core_out_valid,
  input  logic [DataWidth+FFT_OUT_GROWTH-1:0] core_out_re,
  input  logic [DataWidth+FFT_OUT_GROWTH-1:0] core_out_im,
  output logic                                out_valid,
  output logic [DataWidth+FFT_OUT_GROWTH-1:0] out_re,
  output logic [DataWidth+FFT_OUT_GROWTH-1:0] out_im,
  output logic [Log2N-1:0]                    out_idx,
  output logic                                out_last,
  output logic                                busy,
  output logic [15:0]                         frame_cnt,
  output logic                                timeout_err
);

  localparam int OW = DataWidth + FFT_OUT_GROWTH;
  localparam int TW = $clog2(Timeout) + 1;
  localparam logic [Log2N-1:0] LAST_IDX = Log2N'(NPoints - 1);
  localparam logic [TW-1:0]    TMAX     = TW'(Timeout - 1);

  fsm_state_e state_q, state_d;

  logic [Log2N-1:0] in_cnt_q, in_cnt_d;
  logic [Log2N-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             tmo_err_q, tmo_err_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [OW-1:0]    out_re_q, out_re_d;
  logic [OW-1:0]    out_im_q, out_im_d;
  logic [Log2N-1:0] out_idx_q, out_idx_d;
  logic [Log2N-1:0] idx_w;

  logic take, last_in, cap, last_bin, tmo;

`ifdef FFT_BITREV_IDX_EN
  fft_bitrev #(.Log2N(Log2N)) u_bitrev (
    .idx_i(out_cnt_q),
    .idx_o(idx_w)
  );
`else
  assign idx_w = out_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    last_in  = 1'b0;
    cap      = 1'b0;
    last_bin = 1'b0;
    tmo      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          take    = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          take = 1'b1;
          if (in_cnt_q == LAST_IDX) begin
            last_in = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (core_out_valid) begin
          cap     = 1'b1;
          state_d = ST_DRAIN;
        end else if (timer_q == TMAX) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (core_out_valid) begin
          cap = 1'b1;
          if (out_cnt_q == LAST_IDX) begin
            last_bin = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // abort overrides every event of this cycle, including a final sample or bin
    if (abort) begin
      state_d  = ST_IDLE;
      take     = 1'b0;
      last_in  = 1'b0;
      cap      = 1'b0;
      last_bin = 1'b0;
      tmo      = 1'b0;
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    busy       = (state_q != ST_IDLE);
    core_load  = in_ready && in_valid;
    core_start = (state_q == ST_IDLE) && in_valid;
    core_re    = core_load ? in_re : '0;
    core_im    = core_load ? in_im : '0;
  end

  always_comb begin
    in_cnt_d = in_cnt_q;
    if (take) in_cnt_d = last_in ? '0 : in_cnt_q + Log2N'(1);
    timer_d = ((state_q == ST_WAIT) && (state_d == ST_WAIT)) ? timer_q + TW'(1) : '0;
    out_cnt_d = out_cnt_q;
    if (cap) out_cnt_d = last_bin ? '0 : out_cnt_q + Log2N'(1);
    out_valid_d = cap;
    out_last_d  = last_bin;
    out_re_d    = cap ? core_out_re : out_re_q;
    out_im_d    = cap ? core_out_im : out_im_q;
    out_idx_d   = cap ? idx_w : out_idx_q;
    frame_cnt_d = frame_cnt_q + 16'(last_bin);
    tmo_err_d   = tmo_err_q | tmo;
    if (abort) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      timer_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      timer_q     <= '0;
      frame_cnt_q <= '0;
      tmo_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
      tmo_err_q   <= tmo_err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_re      = out_re_q;
  assign out_im      = out_im_q;
  assign out_idx     = out_idx_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: directed vector table plus multi-cycle frame sequences.
module tb_fft_frame_ctrl;

  localparam int DW = 12;
  localparam int OW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_re = '0, in_im = '0;
  logic          core_out_valid = 1'b0;
  logic [OW-1:0] core_out_re = '0, core_out_im = '0;
  logic          in_ready, core_start, core_load, out_valid, out_last, busy, timeout_err;
  logic [DW-1:0] core_re, core_im;
  logic [OW-1:0] out_re, out_im;
  logic [7:0]    out_idx;
  logic [15:0]   frame_cnt;

  fft_frame_ctrl #(.DataWidth(12), .NPoints(256), .Log2N(8), .Timeout(1024)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .core_start(core_start), .core_load(core_load), .core_re(core_re), .core_im(core_im),
    .core_out_valid(core_out_valid), .core_out_re(core_out_re), .core_out_im(core_out_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] res_re(input int k);
    return OW'(k * 1000 - 100000);
  endfunction

  function automatic logic [OW-1:0] res_im(input int k);
    return OW'(5 - k * 37);
  endfunction

  function automatic logic [7:0] exp_idx(input int k);
    logic [7:0] a, r;
    a = 8'(k);
`ifdef FFT_BITREV_IDX_EN
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
`else
    r = a;
`endif
    return r;
  endfunction

  typedef struct {
    logic          v;
    logic          ab;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          e_rdy;
    logic          e_start;
    logic          e_load;
    logic [DW-1:0] e_cre;
    logic          e_busy;
  } vec_t;

  vec_t vecs[10];

  int   r_start, r_load, r_len, r_beats, r_fc_last;
  logic [7:0] r_idx_last;
  bit   r_data_bad, r_ctl_bad, r_rdy_bad, r_out_bad, r_last_seen, r_expired;
  logic [7:0] first4[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; core_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_samples(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_re = 12'(i); in_im = 12'(-i);
      step();
    end
    in_valid = 1'b0;
  endtask

  // One frame in, core model answers lat cycles into WAIT; optional abort/rst on bin cut_bin.
  task automatic do_frame(input bit gappy, input int lat, input int cut_bin, input bit cut_rst);
    int  sent, bout, wcnt, t_start, t_last;
    bit  done;
    sent = 0; bout = 0; wcnt = -1; t_start = -1; t_last = -1; done = 1'b0;
    r_start = 0; r_load = 0; r_beats = 0; r_fc_last = -1; r_idx_last = '0;
    r_data_bad = 0; r_ctl_bad = 0; r_rdy_bad = 0; r_out_bad = 0; r_last_seen = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      abort = 1'b0; rst = 1'b0;
      if (sent < 256) begin
        in_valid = gappy ? (cyc % 2 == 0) : 1'b1;
        in_re = 12'(sent); in_im = 12'(-sent);
      end else begin
        in_valid = (bout < 256); in_re = 12'h5A5; in_im = 12'h3C3;
      end
      core_out_valid = 1'b0; core_out_re = '0; core_out_im = '0;
      if (wcnt >= lat && bout < 256 && !(gappy && (wcnt % 3 == 2))) begin
        core_out_valid = 1'b1; core_out_re = res_re(bout); core_out_im = res_im(bout);
        if (bout == cut_bin) begin
          if (cut_rst) rst = 1'b1;
          else         abort = 1'b1;
        end
      end
      @(negedge clk);
      if (core_start) begin r_start++; if (t_start < 0) t_start = cyc; end
      if (core_load) begin
        r_load++; t_last = cyc;
        if (core_re !== in_re || core_im !== in_im) r_data_bad = 1;
      end
      if (out_valid) begin
        if (out_re !== res_re(r_beats) || out_im !== res_im(r_beats) ||
            out_idx !== exp_idx(r_beats) || out_last !== (r_beats == 255)) r_out_bad = 1;
        if (r_beats < 4) first4[r_beats] = out_idx;
        if (out_last) begin
          r_last_seen = 1; r_fc_last = int'(frame_cnt); r_idx_last = out_idx; done = 1'b1;
        end
        r_beats++;
      end
      if (sent < 256) begin
        if (core_load !== in_valid || in_ready !== 1'b1) r_ctl_bad = 1;
      end else if (!(out_valid && out_last)) begin
        if (core_load !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) r_rdy_bad = 1;
      end
      step();
      if (in_valid && sent < 256) sent++;
      if (core_out_valid) bout++;
      if (sent == 256) wcnt++;
      if (rst || abort) done = 1'b1;
    end
    r_expired = !done;
    r_len = t_last - t_start + 1;
    in_valid = 1'b0; abort = 1'b0; rst = 1'b0; core_out_valid = 1'b0;
  endtask

  task automatic chk_full(input string tag, input int exp_len, input int exp_fc);
    chk({tag, "_done"},     64'(r_expired), 0);
    chk({tag, "_starts"},   64'(r_start), 1);
    chk({tag, "_loads"},    64'(r_load), 256);
    chk({tag, "_load_len"}, 64'(r_len), 64'(exp_len));
    chk({tag, "_core_data"},64'(r_data_bad), 0);
    chk({tag, "_load_ctl"}, 64'(r_ctl_bad), 0);
    chk({tag, "_wait_rdy"}, 64'(r_rdy_bad), 0);
    chk({tag, "_beats"},    64'(r_beats), 256);
    chk({tag, "_out_data"}, 64'(r_out_bad), 0);
    chk({tag, "_last"},     64'(r_last_seen), 1);
    chk({tag, "_idx_last"}, 64'(r_idx_last), 255);
    chk({tag, "_frame_cnt"},64'(r_fc_last), 64'(exp_fc));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 0);
    chk({tag, "_idle_ov"},   64'(out_valid), 0);
    step();
  endtask

  initial begin
    logic [7:0] exp4[4];
    int k;
`ifdef FFT_BITREV_IDX_EN
    exp4 = '{8'd0, 8'd128, 8'd64, 8'd192};
`else
    exp4 = '{8'd0, 8'd1, 8'd2, 8'd3};
`endif
    //        v   ab  re       im       rdy start load cre      busy
    vecs[0] = '{0, 0, 12'd0,   12'd0,   1,  0,    0,   12'd0,   0};
    vecs[1] = '{0, 0, 12'd44,  12'd0,   1,  0,    0,   12'd0,   0};
    vecs[2] = '{1, 0, 12'd5,   12'd7,   1,  1,    1,   12'd5,   0};
    vecs[3] = '{0, 0, 12'd9,   12'd1,   1,  0,    0,   12'd0,   1};
    vecs[4] = '{1, 0, 12'd9,   12'd1,   1,  0,    1,   12'd9,   1};
    vecs[5] = '{1, 1, 12'd3,   12'd2,   1,  0,    1,   12'd3,   1};
    vecs[6] = '{0, 0, 12'd3,   12'd2,   1,  0,    0,   12'd0,   0};
    vecs[7] = '{1, 0, 12'h7FF, 12'h800, 1,  1,    1,   12'h7FF, 0};
    vecs[8] = '{0, 1, 12'd0,   12'd0,   1,  0,    0,   12'd0,   1};
    vecs[9] = '{0, 0, 12'd0,   12'd0,   1,  0,    0,   12'd0,   0};

    do_reset();
    @(negedge clk);
    chk("rst_in_ready",    64'(in_ready), 1);
    chk("rst_out_valid",   64'(out_valid), 0);
    chk("rst_out_re",      64'(out_re), 0);
    chk("rst_out_idx",     64'(out_idx), 0);
    chk("rst_out_last",    64'(out_last), 0);
    chk("rst_frame_cnt",   64'(frame_cnt), 0);
    chk("rst_timeout_err", 64'(timeout_err), 0);
    step();

    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].v; abort = vecs[i].ab; in_re = vecs[i].re; in_im = vecs[i].im;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i),   64'(in_ready),   64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_core_start", i), 64'(core_start), 64'(vecs[i].e_start));
      chk($sformatf("vec%0d_core_load", i),  64'(core_load),  64'(vecs[i].e_load));
      chk($sformatf("vec%0d_core_re", i),    64'(core_re),    64'(vecs[i].e_cre));
      chk($sformatf("vec%0d_busy", i),       64'(busy),       64'(vecs[i].e_busy));
      step();
    end
    in_valid = 1'b0; abort = 1'b0;

    do_frame(1'b0, 20, -1, 1'b0);
    chk_full("f1", 256, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("idx_order%0d", i), 64'(first4[i]), 64'(exp4[i]));

    do_frame(1'b1, 20, -1, 1'b0);
    chk_full("f2", 511, 2);

    send_samples(256);
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (timeout_err === 1'b1) break;
      step();
      k++;
    end
    chk("tmo_cycles",    64'(k), 1024);
    chk("tmo_busy",      64'(busy), 0);
    chk("tmo_in_ready",  64'(in_ready), 1);
    chk("tmo_frame_cnt", 64'(frame_cnt), 2);
    step();
    do_frame(1'b0, 5, -1, 1'b0);
    chk_full("f3", 256, 3);
    chk("f3_tmo_sticky", 64'(timeout_err), 1);

    send_samples(255);
    in_valid = 1'b1; in_re = 12'd255; in_im = 12'(-255); abort = 1'b1;
    step();
    in_valid = 1'b0; abort = 1'b0;
    core_out_valid = 1'b1; core_out_re = 20'd777; core_out_im = 20'd888;
    @(negedge clk);
    chk("ab255_busy",     64'(busy), 0);
    chk("ab255_in_ready", 64'(in_ready), 1);
    step();
    step();
    @(negedge clk);
    chk("ab255_stale_ov", 64'(out_valid), 0);
    chk("ab255_fc",       64'(frame_cnt), 3);
    core_out_valid = 1'b0;
    step();
    do_frame(1'b0, 20, -1, 1'b0);
    chk_full("f4", 256, 4);

    do_frame(1'b0, 3, 255, 1'b0);
    @(negedge clk);
    chk("abl_beats",     64'(r_beats), 255);
    chk("abl_last_seen", 64'(r_last_seen), 0);
    chk("abl_out_valid", 64'(out_valid), 0);
    chk("abl_out_last",  64'(out_last), 0);
    chk("abl_busy",      64'(busy), 0);
    chk("abl_fc",        64'(frame_cnt), 4);
    step();

    do_frame(1'b0, 7, 100, 1'b1);
    @(negedge clk);
    chk("rst100_beats",     64'(r_beats), 100);
    chk("rst100_in_ready",  64'(in_ready), 1);
    chk("rst100_busy",      64'(busy), 0);
    chk("rst100_out_valid", 64'(out_valid), 0);
    chk("rst100_out_re",    64'(out_re), 0);
    chk("rst100_out_im",    64'(out_im), 0);
    chk("rst100_out_idx",   64'(out_idx), 0);
    chk("rst100_out_last",  64'(out_last), 0);
    chk("rst100_fc",        64'(frame_cnt), 0);
    chk("rst100_tmo",       64'(timeout_err), 0);
    chk("rst100_core_load", 64'(core_load), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
